cpu_run_ctrl: RTL and testbench



---
 rtl/cpu_run_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer: turns debug commands into a CPU clock enable and a generated CPU reset.
// Optional breakpoint comparator is built when CPU_RUN_CTRL_BKPT_EN is defined.
module cpu_run_ctrl #(
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 4,
  parameter int PC_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [PC_W-1:0]  pc,
`ifdef CPU_RUN_CTRL_BKPT_EN
  input  logic             bkpt_en,
  input  logic [PC_W-1:0]  bkpt_addr,
`endif
  output logic             cpu_ce,
  output logic             cpu_rst,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [31:0]      cycle_cnt,
  output logic             cmd_err
);

  localparam int RW = $clog2(RST_CYCLES + 1);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_HALT    = 3'd1;
  localparam logic [2:0] OP_RUN     = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_RUN_N   = 3'd4;
  localparam logic [2:0] OP_CPU_RST = 3'd5;

  localparam logic [1:0] CAUSE_CMD   = 2'd0;
  localparam logic [1:0] CAUSE_STEP  = 2'd1;
  localparam logic [1:0] CAUSE_COUNT = 2'd2;
  localparam logic [1:0] CAUSE_BKPT  = 2'd3;

  typedef enum logic [2:0] {
    S_CPURST = 3'd0,
    S_HALTED = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_RUN_N  = 3'd4
  } state_t;

  state_t           r_state, w_nxt_state;
  logic [RW-1:0]    r_rst_cnt, w_nxt_rst_cnt;
  logic [CNT_W-1:0] r_run_cnt, w_nxt_run_cnt;
  logic             r_skip, w_nxt_skip;
  logic [1:0]       r_halt_cause, w_nxt_cause;
  logic [31:0]      r_cycle_cnt;
  logic             r_cmd_err, w_cmd_err;
  logic             w_active, w_bkpt_hit, w_accept, w_running;

  assign w_running = (r_state == S_RUN) || (r_state == S_RUN_N);
  assign w_active  = w_running || (r_state == S_STEP);

`ifdef CPU_RUN_CTRL_BKPT_EN
  // skip masks the breakpoint for the first enabled cycle so execution can leave bkpt_addr
  assign w_bkpt_hit = w_running && bkpt_en && (pc == bkpt_addr) && !r_skip;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
  assign w_bkpt_hit  = 1'b0;
`endif

  assign cpu_ce     = w_active && !w_bkpt_hit;
  assign cpu_rst    = (r_state == S_CPURST);
  assign halted     = (r_state == S_HALTED);
  assign cmd_ready  = (r_state == S_HALTED) || w_running;
  assign halt_cause = r_halt_cause;
  assign cycle_cnt  = r_cycle_cnt;
  assign cmd_err    = r_cmd_err;
  assign w_accept   = cmd_valid && cmd_ready;

  // Next-state, counters, skip flag and halt cause.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_rst_cnt = r_rst_cnt;
    w_nxt_run_cnt = r_run_cnt;
    w_nxt_skip    = r_skip;
    w_nxt_cause   = r_halt_cause;
    w_cmd_err     = 1'b0;
    case (r_state)
      S_CPURST: begin
        if (r_rst_cnt == RW'(RST_CYCLES - 1)) begin
          w_nxt_state   = S_HALTED;
          w_nxt_rst_cnt = '0;
          w_nxt_cause   = CAUSE_CMD;
        end else begin
          w_nxt_rst_cnt = r_rst_cnt + RW'(1);
        end
      end
      S_HALTED: begin
        if (w_accept) begin
          case (cmd_op)
            OP_NOP, OP_HALT: w_nxt_state = S_HALTED;
            OP_RUN: begin
              w_nxt_state = S_RUN;
              w_nxt_skip  = 1'b1;
            end
            OP_STEP: begin
              w_nxt_state = S_STEP;
              w_nxt_skip  = 1'b1;
            end
            OP_RUN_N: begin
              if (cmd_arg != '0) begin
                w_nxt_state   = S_RUN_N;
                w_nxt_run_cnt = cmd_arg;
                w_nxt_skip    = 1'b1;
              end else begin
                w_nxt_cause = CAUSE_COUNT;
              end
            end
            OP_CPU_RST: begin
              w_nxt_state   = S_CPURST;
              w_nxt_rst_cnt = '0;
            end
            default: w_cmd_err = 1'b1;
          endcase
        end else begin
          w_nxt_state = S_HALTED;
        end
      end
      S_STEP: begin
        w_nxt_state = S_HALTED;
        w_nxt_cause = CAUSE_STEP;
        w_nxt_skip  = 1'b0;
      end
      S_RUN, S_RUN_N: begin
        if (cpu_ce) begin
          w_nxt_skip = 1'b0;
        end else begin
          w_nxt_skip = r_skip;
        end
        if ((r_state == S_RUN_N) && cpu_ce) begin
          w_nxt_run_cnt = r_run_cnt - CNT_W'(1);
        end else begin
          w_nxt_run_cnt = r_run_cnt;
        end
        if (w_accept) begin
          case (cmd_op)
            OP_NOP, OP_HALT, OP_CPU_RST: w_cmd_err = 1'b0;
            default:                     w_cmd_err = 1'b1;
          endcase
        end else begin
          w_cmd_err = 1'b0;
        end
        // Count completion and breakpoint outrank a concurrent HALT so the cause stays informative
        if (w_accept && (cmd_op == OP_CPU_RST)) begin
          w_nxt_state   = S_CPURST;
          w_nxt_rst_cnt = '0;
        end else if (w_bkpt_hit) begin
          w_nxt_state = S_HALTED;
          w_nxt_cause = CAUSE_BKPT;
        end else if ((r_state == S_RUN_N) && (r_run_cnt == CNT_W'(1))) begin
          w_nxt_state = S_HALTED;
          w_nxt_cause = CAUSE_COUNT;
        end else if (w_accept && (cmd_op == OP_HALT)) begin
          w_nxt_state = S_HALTED;
          w_nxt_cause = CAUSE_CMD;
        end else begin
          w_nxt_state = r_state;
        end
      end
      default: begin
        w_nxt_state   = S_CPURST;
        w_nxt_rst_cnt = '0;
      end
    endcase
  end

  // State and counter registers; entering CPURST clears the executed-cycle count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_CPURST;
      r_rst_cnt    <= '0;
      r_run_cnt    <= '0;
      r_skip       <= 1'b0;
      r_halt_cause <= CAUSE_CMD;
      r_cycle_cnt  <= 32'd0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_rst_cnt    <= w_nxt_rst_cnt;
      r_run_cnt    <= w_nxt_run_cnt;
      r_skip       <= w_nxt_skip;
      r_halt_cause <= w_nxt_cause;
      r_cmd_err    <= w_cmd_err;
      if (w_nxt_state == S_CPURST) begin
        r_cycle_cnt <= 32'd0;
      end else if (cpu_ce) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end else begin
        r_cycle_cnt <= r_cycle_cnt;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus random commands against a
// budget-based reference model; breakpoint scenarios are built with CPU_RUN_CTRL_BKPT_EN.
module tb_cpu_run_ctrl;

  localparam int RSTC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_arg = 16'd0;
  logic [31:0] pc = 32'd0;
  logic        bkpt_en = 1'b0;
  logic [31:0] bkpt_addr = 32'd0;
  logic        cpu_ce, cpu_rst, halted, cmd_err;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int ce_seen = 0;
  int rst_seen = 0;

  // Reference model: remaining reset cycles and an execution budget (-1 free run, 0 halted)
  int          m_rst_left;
  int          m_left;
  bit          m_step, m_skip, m_err;
  logic [1:0]  m_cause;
  logic [31:0] m_cyc;
  logic [31:0] tb_pc;
  bit          ex_ce, ex_hit, ex_ready, in_rst;

  cpu_run_ctrl #(.CNT_W(16), .RST_CYCLES(RSTC), .PC_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .pc         (pc),
`ifdef CPU_RUN_CTRL_BKPT_EN
    .bkpt_en    (bkpt_en),
    .bkpt_addr  (bkpt_addr),
`endif
    .cpu_ce     (cpu_ce),
    .cpu_rst    (cpu_rst),
    .halted     (halted),
    .halt_cause (halt_cause),
    .cycle_cnt  (cycle_cnt),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rst_left = RSTC;
    m_left     = 0;
    m_step     = 1'b0;
    m_skip     = 1'b0;
    m_err      = 1'b0;
    m_cause    = 2'd0;
    m_cyc      = 32'd0;
    tb_pc      = 32'd0;
  endtask

  task automatic enter_rst();
    m_rst_left = RSTC;
    m_left     = 0;
    m_step     = 1'b0;
    m_cyc      = 32'd0;
    tb_pc      = 32'd0;
  endtask

  task automatic compute_exp();
    in_rst = (m_rst_left > 0) || !reset;
    ex_hit = 1'b0;
`ifdef CPU_RUN_CTRL_BKPT_EN
    ex_hit = !in_rst && (m_left != 0) && !m_step && bkpt_en && (pc == bkpt_addr) && !m_skip;
`endif
    ex_ce    = !in_rst && (m_left != 0) && !ex_hit;
    ex_ready = !in_rst && !m_step;
  endtask

  task automatic model_step(input bit acc, input logic [2:0] op, input logic [15:0] arg);
    bit err;
    err = 1'b0;
    if (!reset) begin
      model_reset();
      return;
    end
    if (ex_ce) begin
      m_cyc  = m_cyc + 32'd1;
      m_skip = 1'b0;
      tb_pc  = tb_pc + 32'd4;
    end
    if (m_rst_left > 0) begin
      m_rst_left--;
      if (m_rst_left == 0) m_cause = 2'd0;
    end else if (m_left == 0) begin
      if (acc) begin
        case (op)
          3'd0, 3'd1: ;
          3'd2: begin m_left = -1; m_skip = 1'b1; end
          3'd3: begin m_left = 1; m_step = 1'b1; m_skip = 1'b1; end
          3'd4: begin
            if (arg != 16'd0) begin m_left = int'(arg); m_skip = 1'b1; end
            else m_cause = 2'd2;
          end
          3'd5: enter_rst();
          default: err = 1'b1;
        endcase
      end
    end else if (m_step) begin
      m_left  = 0;
      m_step  = 1'b0;
      m_cause = 2'd1;
    end else begin
      if (acc && !(op inside {3'd0, 3'd1, 3'd5})) err = 1'b1;
      if (acc && op == 3'd5) enter_rst();
      else if (ex_hit) begin
        m_left  = 0;
        m_cause = 2'd3;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_cause = 2'd2;
        else if (acc && op == 3'd1) begin m_left = 0; m_cause = 2'd0; end
      end else if (acc && op == 3'd1) begin
        m_left  = 0;
        m_cause = 2'd0;
      end
    end
    m_err = err;
  endtask

  // One clock cycle: drive at the falling edge, compare mid-cycle, advance the model at the rising edge
  task automatic tick(input bit v, input logic [2:0] op, input logic [15:0] arg);
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
    pc        = tb_pc;
    #1;
    compute_exp();
    check("cpu_ce",     32'(cpu_ce),     32'(ex_ce));
    check("cmd_ready",  32'(cmd_ready),  32'(ex_ready));
    check("cpu_rst",    32'(cpu_rst),    32'(in_rst));
    check("halted",     32'(halted),     32'(!in_rst && m_left == 0));
    check("halt_cause", 32'(halt_cause), 32'(m_cause));
    check("cycle_cnt",  cycle_cnt,       m_cyc);
    check("cmd_err",    32'(cmd_err),    32'(m_err));
    if (cpu_ce) ce_seen++;
    if (cpu_rst) rst_seen++;
    @(posedge clk);
    model_step(v && ex_ready, op, arg);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 16'd0);
  endtask

  task automatic async_reset_mid();
    #2 reset = 1'b0;
    #1;
    model_reset();
    compute_exp();
    check("async_ce_drop", 32'(cpu_ce), 32'd0);
    check("async_cpu_rst", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    idle(3);
    reset = 1'b1;
    rst_seen = 0;
    idle(7);
    check("rst_len_after_async", 32'(rst_seen), 32'(RSTC));
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // reset sequencing
    idle(3);
    reset = 1'b1;
    rst_seen = 0;
    idle(6);
    check("rst_len", 32'(rst_seen), 32'(RSTC));
    check("halted_after_rst", 32'(halted), 32'd1);
    check("cnt_after_rst", cycle_cnt, 32'd0);

    // three single steps
    ce_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 3'd3, 16'd0);
      idle(2);
      check("step_cause", 32'(halt_cause), 32'd1);
    end
    check("step_ce", 32'(ce_seen), 32'd3);
    check("step_cnt", cycle_cnt, 32'd3);

    // RUN_N 10 and RUN_N 0
    ce_seen = 0;
    tick(1'b1, 3'd4, 16'd10);
    idle(14);
    check("runn10_ce", 32'(ce_seen), 32'd10);
    check("runn10_cause", 32'(halt_cause), 32'd2);
    ce_seen = 0;
    tick(1'b1, 3'd4, 16'd0);
    idle(3);
    check("runn0_ce", 32'(ce_seen), 32'd0);
    check("runn0_cause", 32'(halt_cause), 32'd2);

    // CPU reset, then RUN for 7 cycles and HALT
    tick(1'b1, 3'd5, 16'd0);
    idle(6);
    tick(1'b1, 3'd2, 16'd0);
    idle(6);
    tick(1'b1, 3'd1, 16'd0);
    idle(1);
    check("run_halt_cnt", cycle_cnt, 32'd7);
    check("run_halt_cause", 32'(halt_cause), 32'd0);

    // STEP during RUN is rejected with cmd_err and the run continues
    tick(1'b1, 3'd2, 16'd0);
    idle(2);
    tick(1'b1, 3'd3, 16'd0);
    check("err_pulse", 32'(cmd_err), 32'd1);
    idle(1);
    check("err_single", 32'(cmd_err), 32'd0);
    check("run_continues", 32'(cpu_ce), 32'd1);
    idle(2);
    tick(1'b1, 3'd7, 16'd0);
    tick(1'b1, 3'd1, 16'd0);

    // CPU_RESET during RUN
    tick(1'b1, 3'd2, 16'd0);
    idle(3);
    rst_seen = 0;
    tick(1'b1, 3'd5, 16'd0);
    idle(6);
    check("cmdrst_len", 32'(rst_seen), 32'(RSTC));
    check("cmdrst_cnt", cycle_cnt, 32'd0);

    // async reset mid RUN_N
    tick(1'b1, 3'd4, 16'd20);
    idle(3);
    async_reset_mid();

`ifdef CPU_RUN_CTRL_BKPT_EN
    bkpt_addr = 32'h10;
    bkpt_en   = 1'b1;
    tick(1'b1, 3'd2, 16'd0);
    idle(8);
    check("bkpt_cnt", cycle_cnt, 32'd4);
    check("bkpt_cause", 32'(halt_cause), 32'd3);
    tick(1'b1, 3'd2, 16'd0);
    idle(3);
    tick(1'b1, 3'd1, 16'd0);
    idle(1);
    check("bkpt_resume_cnt", cycle_cnt, 32'd8);
    bkpt_addr = tb_pc + 32'd8;
    tick(1'b1, 3'd2, 16'd0);
    idle(2);
    tick(1'b1, 3'd1, 16'd0);
    idle(1);
    check("bkpt_halt_same_edge", 32'(halt_cause), 32'd3);
    bkpt_en = 1'b0;
`endif

    // random command stream
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        async_reset_mid();
      end else begin
`ifdef CPU_RUN_CTRL_BKPT_EN
        bkpt_en = ($urandom_range(0, 3) == 0);
        if (r < 20) bkpt_addr = tb_pc + 32'(4 * $urandom_range(0, 5));
`endif
        tick(($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)), 16'($urandom_range(0, 12)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
